// File: rtl/controle_estados_pkg.sv
// rtl/controle_estados_pkg.sv - shared state encodings and branch decode constants for controle_estados
package controle_estados_pkg;

    typedef logic [3:0] estado_t;

    localparam estado_t ST_FETCH  = 4'b0001;
    localparam estado_t ST_DECODE = 4'b0010;
    localparam estado_t ST_EXEC   = 4'b0100;
    localparam estado_t ST_UPDATE = 4'b1000;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam int OFF_W = 13;

endpackage

// File: rtl/controle_estados_decod_desvio.sv
// rtl/controle_estados_decod_desvio.sv - B-type branch offset extraction into magnitude and sign
module decod_desvio
    import controle_estados_pkg::*;
#(
    parameter int IMM_W = 12
) (
    input  logic [31:0]      instr,
    output logic [IMM_W-1:0] imediato,
    output logic             negativo
);

    localparam int MAG_W = (IMM_W > OFF_W) ? IMM_W : OFF_W;

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] mag;
    logic [MAG_W-1:0] mag_ext;
    logic             unused_bits;

    // Reassemble the scattered offset, then fold it to magnitude/sign; -4096 wraps as accepted
    always_comb begin
        off      = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        negativo = off[OFF_W-1];
        mag      = negativo ? (~off + 13'd1) : off;
        mag_ext  = MAG_W'(mag);
        imediato = mag_ext[IMM_W-1:0];
    end

    assign unused_bits = ^{instr[24:12], instr[6:0]};

endmodule

// File: rtl/controle_estados.sv
// rtl/controle_estados.sv - multicycle fetch/decode/exec/update sequencer with instruction register; CONTROLE_BNE_EN enables bne
module controle_estados
    import controle_estados_pkg::*;
#(
    parameter int IMM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      PC,
    output logic [31:0]      imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    input  logic             alu_zero,
    output logic [31:0]      instr,
    output logic [3:0]       estado,
    output logic             pcsrc,
    output logic [IMM_W-1:0] imediato,
    output logic             negativo
);

    estado_t          state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      instr_q, instr_d;
    logic             pcsrc_q, pcsrc_d;
    logic [IMM_W-1:0] imediato_q, imediato_d;
    logic             negativo_q, negativo_d;

    logic [IMM_W-1:0] dec_imediato;
    logic             dec_negativo;
    logic             branch_taken;
    logic [6:0]       opcode;
    logic [2:0]       funct3;

    decod_desvio #(
        .IMM_W(IMM_W)
    ) u_decod_desvio (
        .instr    (instr_q),
        .imediato (dec_imediato),
        .negativo (dec_negativo)
    );

    // State and datapath registers; reset drops any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            req_q      <= 1'b0;
            instr_q    <= 32'd0;
            pcsrc_q    <= 1'b0;
            imediato_q <= '0;
            negativo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pcsrc_q    <= pcsrc_d;
            imediato_q <= imediato_d;
            negativo_q <= negativo_d;
        end
    end

    // Next state: fetch waits for an acknowledged request, other states last one cycle
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = (req_q && imem_ack) ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Branch condition from the held instruction and the ALU zero flag
    always_comb begin
        opcode       = instr_q[6:0];
        funct3       = instr_q[14:12];
        branch_taken = 1'b0;
        if (opcode == OPC_BRANCH) begin
            if (funct3 == F3_BEQ && alu_zero)
                branch_taken = 1'b1;
`ifdef CONTROLE_BNE_EN
            if (funct3 == F3_BNE && !alu_zero)
                branch_taken = 1'b1;
`endif
        end
    end

    // Per-state register updates: request/latch in fetch, offset in decode, pcsrc in exec
    always_comb begin
        req_d      = req_q;
        instr_d    = instr_q;
        pcsrc_d    = pcsrc_q;
        imediato_d = imediato_q;
        negativo_d = negativo_q;
        case (state_q)
            ST_FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_data;
                    req_d   = 1'b0;
                end
            end
            ST_DECODE: begin
                imediato_d = dec_imediato;
                negativo_d = dec_negativo;
            end
            ST_EXEC: begin
                pcsrc_d = branch_taken;
            end
            ST_UPDATE: begin
                req_d = 1'b0;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    assign imem_addr = PC;
    assign imem_req  = req_q;
    assign instr     = instr_q;
    assign estado    = state_q;
    assign pcsrc     = pcsrc_q;
    assign imediato  = imediato_q;
    assign negativo  = negativo_q;

endmodule

// File: tb/tb_controle_estados.sv
// tb/tb_controle_estados.sv - scoreboard bench for controle_estados
module tb_controle_estados;

    localparam logic [3:0] E_FETCH  = 4'b0001;
    localparam logic [3:0] E_DECODE = 4'b0010;
    localparam logic [3:0] E_EXEC   = 4'b0100;
    localparam logic [3:0] E_UPDATE = 4'b1000;

`ifdef CONTROLE_BNE_EN
    localparam logic BNE_ON = 1'b1;
`else
    localparam logic BNE_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] word;
        logic        pcsrc;
        logic [11:0] imm;
        logic        neg;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        alu_zero;
    logic [31:0] instr;
    logic [3:0]  estado;
    logic        pcsrc;
    logic [11:0] imediato;
    logic        negativo;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    controle_estados dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC        (pc),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .alu_zero  (alu_zero),
        .instr     (instr),
        .estado    (estado),
        .pcsrc     (pcsrc),
        .imediato  (imediato),
        .negativo  (negativo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in the first FETCH cycle; returns at the negedge after UPDATE
    task automatic run_instr(input string tag, input logic [31:0] word, input logic zero,
                             input int delay, input logic e_pcsrc, input logic [11:0] e_imm,
                             input logic e_neg);
        exp_t e;
        exp_t got;
        int   cyc;
        int   rc;
        bit   done;
        e.word   = word;
        e.pcsrc  = e_pcsrc;
        e.imm    = e_imm;
        e.neg    = e_neg;
        e.cycles = 5 + (delay - 1);
        sb.push_back(e);
        cyc  = 0;
        rc   = 0;
        done = 1'b0;
        pc   = pc + 32'd1;
        while (!done && cyc < 200) begin
            cyc++;
            if (cyc == 2) check({tag, ".req_first"}, {31'd0, imem_req}, 32'd1);
            if (estado == E_UPDATE) begin
                done = 1'b1;
            end else begin
                if (imem_req) rc++;
                imem_ack  = imem_req && (rc == delay);
                imem_data = imem_ack ? word : 32'hDEADBEEF;
                alu_zero  = zero;
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        got = sb.pop_front();
        check({tag, ".instr"},    instr,               got.word);
        check({tag, ".pcsrc"},    {31'd0, pcsrc},      {31'd0, got.pcsrc});
        check({tag, ".imediato"}, {20'd0, imediato},   {20'd0, got.imm});
        check({tag, ".negativo"}, {31'd0, negativo},   {31'd0, got.neg});
        check({tag, ".cycles"},   cyc,                 got.cycles);
        check({tag, ".imem_addr"}, imem_addr,          pc);
        @(negedge clk);
        check({tag, ".after_upd"}, {28'd0, estado},    {28'd0, E_FETCH});
        check({tag, ".req_after"}, {31'd0, imem_req},  32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        pc        = 32'd0;
        imem_ack  = 1'b0;
        imem_data = 32'd0;
        alu_zero  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.estado",   {28'd0, estado},   {28'd0, E_FETCH});
        check("rst.req",      {31'd0, imem_req}, 32'd0);
        check("rst.instr",    instr,             32'd0);
        check("rst.pcsrc",    {31'd0, pcsrc},    32'd0);
        check("rst.imediato", {20'd0, imediato}, 32'd0);
        check("rst.negativo", {31'd0, negativo}, 32'd0);
        rst_n = 1'b1;

        run_instr("beq_taken",   32'h00000463, 1'b1, 3, 1'b1,   12'd8,    1'b0);
        run_instr("beq_not",     32'h00000463, 1'b0, 1, 1'b0,   12'd8,    1'b0);
        run_instr("bne_neg",     32'hFE001CE3, 1'b0, 2, BNE_ON, 12'd8,    1'b1);
        run_instr("bne_zero",    32'hFE001CE3, 1'b1, 1, 1'b0,   12'd8,    1'b1);
        run_instr("addi",        32'h00500093, 1'b1, 1, 1'b0,   12'd2048, 1'b0);
        run_instr("off_m4096",   32'h80000063, 1'b1, 4, 1'b1,   12'd0,    1'b1);

        // Reset while a request is outstanding, then hammer ack during reset
        @(negedge clk);
        check("mid.req_before", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.req_async",  {31'd0, imem_req}, 32'd0);
        check("mid.estado",     {28'd0, estado},   {28'd0, E_FETCH});
        check("mid.instr",      instr,             32'd0);
        check("mid.pcsrc",      {31'd0, pcsrc},    32'd0);
        imem_ack  = 1'b1;
        imem_data = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        check("mid.instr_held", instr,             32'd0);
        check("mid.req_held",   {31'd0, imem_req}, 32'd0);
        imem_ack  = 1'b0;
        rst_n     = 1'b1;

        run_instr("post_rst",    32'h00000463, 1'b1, 1, 1'b1,   12'd8,    1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
